// File: rtl/reg_wb_pkg.sv
// Shared definitions for the register-file writeback path.
//   XLEN, AW    : default data width and register address width
//   wb_entry_t  : shape of one writeback entry {live, rd, data}
//   clog2       : ceiling log2, used to size pointers and occupancy counters
package reg_wb_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    typedef struct packed {
        logic            live;
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/reg_wb_fifo.sv
// In-order buffer for memory/load results waiting for the register-file port.
// Circular buffer with head/tail pointers. Every occupied entry carries a live
// bit that can be cleared by a younger write to the same register (kill).
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   push, push_rd/push_data enqueue a new live entry at the tail
//   pop                     drop the head entry
//   kill_valid, kill_rd     clear live on every stored entry whose rd matches
//   count, full, empty      occupancy
//   head_live/rd/data       oldest entry
//   ord_valid/live/rd/data  all entries in age order, index 0 = oldest
module reg_wb_fifo #(
    parameter int DEPTH = 4,
    parameter int XLEN  = reg_wb_pkg::XLEN,
    parameter int AW    = reg_wb_pkg::AW
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             push,
    input  logic [AW-1:0]                    push_rd,
    input  logic [XLEN-1:0]                  push_data,
    input  logic                             pop,
    input  logic                             kill_valid,
    input  logic [AW-1:0]                    kill_rd,
    output logic [reg_wb_pkg::clog2(DEPTH):0] count,
    output logic                             full,
    output logic                             empty,
    output logic                             head_live,
    output logic [AW-1:0]                    head_rd,
    output logic [XLEN-1:0]                  head_data,
    output logic [DEPTH-1:0]                 ord_valid,
    output logic [DEPTH-1:0]                 ord_live,
    output logic [DEPTH*AW-1:0]              ord_rd,
    output logic [DEPTH*XLEN-1:0]            ord_data
);
    import reg_wb_pkg::*;

    localparam int PW = clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]         head_reg;
    logic [PW-1:0]         tail_reg;
    logic [CW-1:0]         count_reg;
    logic [DEPTH-1:0]      slot_live;
    logic [DEPTH*AW-1:0]   slot_rd;
    logic [DEPTH*XLEN-1:0] slot_data;
    logic                  push_ok;
    logic                  pop_ok;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign count   = count_reg;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic            live_q;
            logic [AW-1:0]   rd_q;
            logic [XLEN-1:0] data_q;

            // A push into this slot wins over a kill: an entry arriving in the
            // same cycle as the ALU write is younger and must survive.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    live_q <= 1'b0;
                    rd_q   <= '0;
                    data_q <= '0;
                end else if (push_ok && (tail_reg == PW'(gi))) begin
                    live_q <= 1'b1;
                    rd_q   <= push_rd;
                    data_q <= push_data;
                end else if (kill_valid && (rd_q == kill_rd)) begin
                    live_q <= 1'b0;
                end
            end

            assign slot_live[gi]                = live_q;
            assign slot_rd[gi*AW +: AW]         = rd_q;
            assign slot_data[gi*XLEN +: XLEN]   = data_q;
        end

        // Rotate the physical slots so index 0 is always the head.
        for (gi = 0; gi < DEPTH; gi++) begin : g_ord
            logic [PW-1:0] idx;
            assign idx                         = head_reg + PW'(gi);
            assign ord_valid[gi]               = (count_reg > CW'(gi));
            assign ord_live[gi]                = slot_live[idx];
            assign ord_rd[gi*AW +: AW]         = slot_rd[idx*AW +: AW];
            assign ord_data[gi*XLEN +: XLEN]   = slot_data[idx*XLEN +: XLEN];
        end
    endgenerate

    assign head_live = ord_live[0];
    assign head_rd   = ord_rd[AW-1:0];
    assign head_data = ord_data[XLEN-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push_ok) begin
                tail_reg <= tail_reg + 1'b1;
            end
            if (pop_ok) begin
                head_reg <= head_reg + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_writeback_queue.sv
// Owner of the single register-file write port. Single-cycle ALU results go
// straight to the output stage; memory results wait in an in-order queue and
// take the port whenever the ALU does not. Decode read addresses are snooped
// so values still in flight can be forwarded.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   alu_valid/alu_rd/alu_data       ALU result (no backpressure)
//   mem_valid/mem_rd/mem_data       memory result, accepted when mem_ready
//   mem_ready                       queue has a free slot
//   REG_write_1/address_wr/data_wb_in1  registered register-file write port
//   REG_address1/2                  decode read addresses (snooped)
//   fwd1/2_hit, fwd1/2_data         forwarding result per read address
//   count                           memory queue occupancy
module reg_writeback_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = reg_wb_pkg::XLEN,
    parameter int AW    = reg_wb_pkg::AW
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             alu_valid,
    input  logic [AW-1:0]                    alu_rd,
    input  logic [XLEN-1:0]                  alu_data,
    input  logic                             mem_valid,
    input  logic [AW-1:0]                    mem_rd,
    input  logic [XLEN-1:0]                  mem_data,
    output logic                             mem_ready,
    output logic                             REG_write_1,
    output logic [AW-1:0]                    REG_address_wr,
    output logic [XLEN-1:0]                  REG_data_wb_in1,
    input  logic [AW-1:0]                    REG_address1,
    input  logic [AW-1:0]                    REG_address2,
    output logic                             fwd1_hit,
    output logic                             fwd2_hit,
    output logic [XLEN-1:0]                  fwd1_data,
    output logic [XLEN-1:0]                  fwd2_data,
    output logic [reg_wb_pkg::clog2(DEPTH):0] count
);
    import reg_wb_pkg::*;

    localparam int CW = clog2(DEPTH) + 1;

    logic                  alu_acc;
    logic                  mem_push;
    logic                  q_pop;
    logic [CW-1:0]         q_count;
    logic                  q_full;
    logic                  q_empty;
    logic                  head_live;
    logic [AW-1:0]         head_rd;
    logic [XLEN-1:0]       head_data;
    logic [DEPTH-1:0]      ord_valid;
    logic [DEPTH-1:0]      ord_live;
    logic [DEPTH*AW-1:0]   ord_rd;
    logic [DEPTH*XLEN-1:0] ord_data;

    // Register 0 is hard-wired: its writes are dropped, but a memory transfer
    // to it still completes the handshake.
    assign alu_acc   = alu_valid && (alu_rd != '0);
    assign mem_ready = !q_full;
    assign mem_push  = mem_valid && mem_ready && (mem_rd != '0);
    assign q_pop     = !alu_acc && !q_empty;
    assign count     = q_count;

    reg_wb_fifo #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN),
        .AW    (AW)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (mem_push),
        .push_rd    (mem_rd),
        .push_data  (mem_data),
        .pop        (q_pop),
        .kill_valid (alu_acc),
        .kill_rd    (alu_rd),
        .count      (q_count),
        .full       (q_full),
        .empty      (q_empty),
        .head_live  (head_live),
        .head_rd    (head_rd),
        .head_data  (head_data),
        .ord_valid  (ord_valid),
        .ord_live   (ord_live),
        .ord_rd     (ord_rd),
        .ord_data   (ord_data)
    );

    // Output stage: ALU first, then the queue head. A killed head still pops,
    // carrying live=0 into the write enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            REG_write_1     <= 1'b0;
            REG_address_wr  <= '0;
            REG_data_wb_in1 <= '0;
        end else if (alu_acc) begin
            REG_write_1     <= 1'b1;
            REG_address_wr  <= alu_rd;
            REG_data_wb_in1 <= alu_data;
        end else if (!q_empty) begin
            REG_write_1     <= head_live;
            REG_address_wr  <= head_rd;
            REG_data_wb_in1 <= head_data;
        end else begin
            REG_write_1     <= 1'b0;
        end
    end

    logic [2*AW-1:0]   rd_addrs;
    logic [1:0]        fwd_hit;
    logic [2*XLEN-1:0] fwd_data;

    assign rd_addrs = {REG_address2, REG_address1};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic [AW-1:0]   addr;
            logic            hit;
            logic [XLEN-1:0] data;

            assign addr = rd_addrs[gi*AW +: AW];

            // Scan oldest to youngest so the last match (youngest) wins; the
            // output stage is older than anything still queued.
            always_comb begin
                hit  = 1'b0;
                data = '0;
                if (addr != '0) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (ord_valid[i] && ord_live[i] &&
                            (ord_rd[i*AW +: AW] == addr)) begin
                            hit  = 1'b1;
                            data = ord_data[i*XLEN +: XLEN];
                        end
                    end
                    if (!hit && REG_write_1 && (REG_address_wr == addr)) begin
                        hit  = 1'b1;
                        data = REG_data_wb_in1;
                    end
                end
            end

            assign fwd_hit[gi]                = hit;
            assign fwd_data[gi*XLEN +: XLEN]  = data;
        end
    endgenerate

    assign fwd1_hit  = fwd_hit[0];
    assign fwd2_hit  = fwd_hit[1];
    assign fwd1_data = fwd_data[XLEN-1:0];
    assign fwd2_data = fwd_data[2*XLEN-1:XLEN];

endmodule
